serdes_lb_chk: RTL
==================

SERDES_LB_CHK -- requirements
Module: serdes_lb_chk

Interface
REQ-001 Parameter NBYTES, default 8, bytes per parallel word; legal values 2, 4, 8 (SERDES 20/40/80-bit datapath).
REQ-002 Parameter MODE, default 0, pattern select: 0 counter, 1 comma-fill, 2 PRBS-7.
REQ-003 Parameter K_POS, default 0, byte lane carrying K28.5 in comma-fill mode and idle words; range 0..NBYTES-1.
REQ-004 Parameter LOCK_CNT, default 16, consecutive good words needed to declare lock.
REQ-005 Parameter LOSS_CNT, default 4, consecutive bad words that drop lock.
REQ-006 Parameter ERR_W, default 16, error counter width.
REQ-007 ref_clk  in  1  single clock for generator and checker (SERDES TX and RX clocks tied together in loopback).
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 en_i  in  1  generator advance enable.
REQ-010 tx_data_o  out  8*NBYTES  TX word to SERDES; byte 0 in bits [7:0].
REQ-011 tx_k_o  out  NBYTES  per-byte K flag to SERDES.
REQ-012 rx_data_i  in  8*NBYTES  RX word from SERDES.
REQ-013 rx_k_i  in  NBYTES  per-byte K flag from SERDES.
REQ-014 rx_valid_i  in  1  RX word valid (byte aligned, reset done).
REQ-015 err_clr_i  in  1  clears err_cnt_o.
REQ-016 locked_o  out  1  checker locked.
REQ-017 err_o  out  1  one-cycle pulse per bad word while locked.
REQ-018 err_cnt_o  out  ERR_W  saturating bad-word count.

Function
REQ-019 Counter mode: byte i of word n = (n*NBYTES + i) mod 256, n starting at 0 after reset; tx_k_o = 0.
REQ-020 Comma-fill mode: byte K_POS = 8'hBC with K=1, all other bytes 8'h4A with K=0, constant every cycle.
REQ-021 PRBS-7 mode: polynomial x^7+x^6+1, seed 7'h7F, 8*NBYTES bits per word, first generated bit in bit 0; tx_k_o = 0.
REQ-022 Generator advances one word per cycle when en_i=1; when en_i=0, the generator holds its state and tx_data_o/tx_k_o output the comma-fill idle word.
REQ-023 tx_data_o/tx_k_o are registered; the first patterned word appears in the cycle after the first en_i=1 edge.
REQ-024 RX inputs are registered once; a word with rx_valid_i=0 is ignored and the expected word does not advance.
REQ-025 Checker states: HUNT, CHECK, LOCKED.
REQ-026 HUNT: the first valid word seeds the expected generator (counter: byte 0 value; PRBS: upper 7 received bits; comma: no seed) -> CHECK, good count 0.
REQ-027 CHECK: word good iff rx_data and rx_k equal expected; LOCK_CNT consecutive good -> LOCKED; any bad -> HUNT.
REQ-028 LOCKED: bad word increments err_cnt_o and pulses err_o; LOSS_CNT consecutive bad -> HUNT, locked_o=0; a good word resets the bad-run count.
REQ-029 Latency: a word sampled at edge t is reflected on locked_o/err_o/err_cnt_o after edge t+2.
REQ-030 err_cnt_o saturates at 2^ERR_W-1; err_clr_i has priority over a simultaneous increment (result 0).
REQ-031 Mismatches in HUNT or CHECK never touch err_o/err_cnt_o.

Reset
REQ-032 On rst: tx_data_o/tx_k_o = idle word, generator at word 0/seed 7'h7F, state HUNT, locked_o=0, err_o=0, err_cnt_o=0, run counters 0.
REQ-033 rst asserted mid-operation has the same effect in the following cycle; no partial state survives.

Structure
REQ-034 Package serdes_lb_pkg holds the MODE encodings, K28_5=8'hBC, FILL=8'h4A, PRBS7 seed, and the checker state typedef.
REQ-035 Sub-module serdes_lb_pattern (pattern generator with load/seed port) is instanced twice: TX generator and RX expected-word generator.

Verification
REQ-036 NBYTES=4, MODE=0, en_i=1 from reset -> tx_data_o 32'h03020100 then 32'h07060504; looped to RX with rx_valid_i=1 -> locked_o=1 after 1+16 valid words plus 2 cycles.
REQ-037 Locked, flip one bit in one word -> err_o single pulse, err_cnt_o=1, locked_o stays 1.
REQ-038 Locked, 4 consecutive corrupted words -> err_cnt_o=4, locked_o=0 after the 4th; clean data resumes -> relock after 17 valid words.
REQ-039 NBYTES=8, MODE=1, K_POS=3 -> tx_data_o 64'h4A4A4A4A_BC4A4A4A, tx_k_o 8'h08; loopback locks, err_cnt_o stays 0.
REQ-040 MODE=2, locked, rx_valid_i low 5 cycles mid-stream (TX held via en_i) -> no error; ERR_W=4, LOSS_CNT=32, 20 bad words -> err_cnt_o=15; err_clr_i with bad word -> 0.

Source files
------------

// File: rtl/serdes_lb_pkg.sv
// Shared encodings, control characters and checker state type for the SERDES
// loopback pattern generator/checker.
package serdes_lb_pkg;

  localparam int unsigned ModeCounter = 0;
  localparam int unsigned ModeComma   = 1;
  localparam int unsigned ModePrbs    = 2;

  localparam logic [7:0] K28_5      = 8'hBC;
  localparam logic [7:0] FILL       = 8'h4A;
  localparam logic [6:0] PRBS7_SEED = 7'h7F;

  typedef enum logic [1:0] {
    StHunt,
    StCheck,
    StLocked
  } chk_state_e;

endpackage

// File: rtl/serdes_lb_pattern.sv
// Word-wide pattern generator (counter, comma-fill or PRBS-7) with a load port
// so the checker can resynchronise it to the received stream.
module serdes_lb_pattern
  import serdes_lb_pkg::*;
#(
  parameter int unsigned NBYTES = 8,
  parameter int unsigned MODE   = 0,
  parameter int unsigned K_POS  = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  adv_i,
  input  logic                  load_i,
  input  logic [7:0]            load_cnt_i,
  input  logic [6:0]            load_lfsr_i,
  output logic [8*NBYTES-1:0]   data_o,
  output logic [NBYTES-1:0]     k_o
);

  localparam int unsigned W = 8 * NBYTES;

  logic [7:0]   cnt_q, cnt_d;
  logic [6:0]   lfsr_q, lfsr_d;
  logic [6:0]   lfsr_walk;
  logic [W-1:0] prbs_word;

  // x^7+x^6+1 stepped W times; the first generated bit lands in bit 0.
  always_comb begin
    lfsr_walk = lfsr_q;
    prbs_word = '0;
    for (int unsigned i = 0; i < W; i++) begin
      prbs_word[i] = lfsr_walk[6] ^ lfsr_walk[5];
      lfsr_walk    = {lfsr_walk[5:0], lfsr_walk[6] ^ lfsr_walk[5]};
    end
  end

  always_comb begin
    data_o = '0;
    k_o    = '0;
    if (MODE == ModeComma) begin
      for (int unsigned i = 0; i < NBYTES; i++) begin
        data_o[8*i +: 8] = (i == K_POS) ? K28_5 : FILL;
        k_o[i]           = (i == K_POS);
      end
    end else if (MODE == ModePrbs) begin
      data_o = prbs_word;
    end else begin
      for (int unsigned i = 0; i < NBYTES; i++) begin
        data_o[8*i +: 8] = cnt_q + 8'(i);
      end
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    lfsr_d = lfsr_q;
    if (load_i) begin
      cnt_d  = load_cnt_i;
      lfsr_d = load_lfsr_i;
    end else if (adv_i) begin
      cnt_d  = cnt_q + 8'(NBYTES);
      lfsr_d = lfsr_walk;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      lfsr_q <= PRBS7_SEED;
    end else begin
      cnt_q  <= cnt_d;
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/serdes_lb_chk.sv
// SERDES loopback tester: registered TX pattern source and an RX checker that
// hunts, verifies and locks onto the same pattern, counting errors while locked.
module serdes_lb_chk
  import serdes_lb_pkg::*;
#(
  parameter int unsigned NBYTES   = 8,
  parameter int unsigned MODE     = 0,
  parameter int unsigned K_POS    = 0,
  parameter int unsigned LOCK_CNT = 16,
  parameter int unsigned LOSS_CNT = 4,
  parameter int unsigned ERR_W    = 16
) (
  input  logic                ref_clk,
  input  logic                rst,
  input  logic                en_i,
  output logic [8*NBYTES-1:0] tx_data_o,
  output logic [NBYTES-1:0]   tx_k_o,
  input  logic [8*NBYTES-1:0] rx_data_i,
  input  logic [NBYTES-1:0]   rx_k_i,
  input  logic                rx_valid_i,
  input  logic                err_clr_i,
  output logic                locked_o,
  output logic                err_o,
  output logic [ERR_W-1:0]    err_cnt_o
);

  localparam int unsigned W     = 8 * NBYTES;
  localparam int unsigned GoodW = $clog2(LOCK_CNT + 1);
  localparam int unsigned LossW = $clog2(LOSS_CNT + 1);

  logic [W-1:0]      idle_data;
  logic [NBYTES-1:0] idle_k;
  logic [W-1:0]      tx_pat_data;
  logic [NBYTES-1:0] tx_pat_k;
  logic [W-1:0]      tx_data_q;
  logic [NBYTES-1:0] tx_k_q;

  logic [W-1:0]      rx_data_q;
  logic [NBYTES-1:0] rx_k_q;
  logic              rx_valid_q;

  logic [W-1:0]      exp_data;
  logic [NBYTES-1:0] exp_k;
  logic [7:0]        seed_cnt;
  logic [6:0]        seed_lfsr;
  logic              exp_load, exp_adv, word_good;

  chk_state_e        state_q, state_d;
  logic [GoodW-1:0]  good_cnt_q, good_cnt_d;
  logic [LossW-1:0]  bad_cnt_q, bad_cnt_d;
  logic              err_pend_q, err_pend_d;
  logic              locked_q, err_q;
  logic [ERR_W-1:0]  err_cnt_q;

  always_comb begin
    idle_data = '0;
    idle_k    = '0;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      idle_data[8*i +: 8] = (i == K_POS) ? K28_5 : FILL;
      idle_k[i]           = (i == K_POS);
    end
  end

  serdes_lb_pattern #(
    .NBYTES (NBYTES),
    .MODE   (MODE),
    .K_POS  (K_POS)
  ) u_tx_gen (
    .clk_i       (ref_clk),
    .rst_i       (rst),
    .adv_i       (en_i),
    .load_i      (1'b0),
    .load_cnt_i  (8'h00),
    .load_lfsr_i (7'h00),
    .data_o      (tx_pat_data),
    .k_o         (tx_pat_k)
  );

  always_ff @(posedge ref_clk) begin
    if (rst) begin
      tx_data_q  <= idle_data;
      tx_k_q     <= idle_k;
      rx_data_q  <= '0;
      rx_k_q     <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      tx_data_q  <= en_i ? tx_pat_data : idle_data;
      tx_k_q     <= en_i ? tx_pat_k : idle_k;
      rx_data_q  <= rx_data_i;
      rx_k_q     <= rx_k_i;
      rx_valid_q <= rx_valid_i;
    end
  end

  // Seeds describe the word after the received one, so the next compare lines up.
  always_comb begin
    seed_cnt = rx_data_q[7:0] + 8'(NBYTES);
    for (int unsigned i = 0; i < 7; i++) begin
      seed_lfsr[i] = rx_data_q[W-1-i];
    end
  end

  assign exp_load = rx_valid_q && (state_q == StHunt);
  assign exp_adv  = rx_valid_q && (state_q != StHunt);

  serdes_lb_pattern #(
    .NBYTES (NBYTES),
    .MODE   (MODE),
    .K_POS  (K_POS)
  ) u_exp_gen (
    .clk_i       (ref_clk),
    .rst_i       (rst),
    .adv_i       (exp_adv),
    .load_i      (exp_load),
    .load_cnt_i  (seed_cnt),
    .load_lfsr_i (seed_lfsr),
    .data_o      (exp_data),
    .k_o         (exp_k)
  );

  assign word_good = (rx_data_q == exp_data) && (rx_k_q == exp_k);

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    err_pend_d = 1'b0;
    if (rx_valid_q) begin
      unique case (state_q)
        StHunt: begin
          state_d    = StCheck;
          good_cnt_d = '0;
        end
        StCheck: begin
          if (!word_good) begin
            state_d = StHunt;
          end else if (good_cnt_q == GoodW'(LOCK_CNT - 1)) begin
            state_d   = StLocked;
            bad_cnt_d = '0;
          end else begin
            good_cnt_d = good_cnt_q + 1'b1;
          end
        end
        StLocked: begin
          if (word_good) begin
            bad_cnt_d = '0;
          end else begin
            err_pend_d = 1'b1;
            if (bad_cnt_q == LossW'(LOSS_CNT - 1)) begin
              state_d = StHunt;
            end else begin
              bad_cnt_d = bad_cnt_q + 1'b1;
            end
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  always_ff @(posedge ref_clk) begin
    if (rst) begin
      state_q    <= StHunt;
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
      err_pend_q <= 1'b0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
      err_pend_q <= err_pend_d;
      locked_q   <= (state_q == StLocked);
      err_q      <= err_pend_q;
      if (err_clr_i) begin
        err_cnt_q <= '0;
      end else if (err_pend_q && (err_cnt_q != '1)) begin
        err_cnt_q <= err_cnt_q + 1'b1;
      end
    end
  end

  assign tx_data_o = tx_data_q;
  assign tx_k_o    = tx_k_q;
  assign locked_o  = locked_q;
  assign err_o     = err_q;
  assign err_cnt_o = err_cnt_q;

endmodule
